// File: rtl/pdm_pkg.sv
// Shared types and constants for the path delay meter.
package pdm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        RISE = 3'd2,
        FALL = 3'd3,
        DONE = 3'd4
    } pdm_state_e;

    localparam int SYNC_STAGES     = 2;
    // A zero-delay path still reads back the synchronizer latency.
    localparam int ZERO_DELAY_READ = SYNC_STAGES;

endpackage

// File: rtl/pdm_sync.sv
// Multi-flop synchronizer bringing the path-under-test output into the C domain.
module pdm_sync
    import pdm_pkg::*;
(
    input  logic C,
    input  logic R,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchronizer stages
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launches a rise then a fall on A and counts cycles until Y follows each edge.
// Optional min/max tracking of captured delays is enabled by defining PDM_MINMAX_EN.
module path_delay_meter #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             START,
    output logic             A,
    input  logic             Y,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] T_RISE,
    output logic [CNT_W-1:0] T_FALL
`ifdef PDM_MINMAX_EN
    ,
    output logic [CNT_W-1:0] T_MIN,
    output logic [CNT_W-1:0] T_MAX
`endif
);

    import pdm_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE - 1);

    pdm_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_a, w_a_nxt;
    logic             r_done;
    logic             r_timeout, w_timeout_nxt;
    logic [CNT_W-1:0] r_t_rise, w_t_rise_nxt;
    logic [CNT_W-1:0] r_t_fall, w_t_fall_nxt;
    logic             w_ys;

    pdm_sync u_sync (
        .C   (C),
        .R   (R),
        .i_d (Y),
        .o_q (w_ys)
    );

    // Next-state, counter and result decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_a_nxt       = r_a;
        w_timeout_nxt = r_timeout;
        w_t_rise_nxt  = r_t_rise;
        w_t_fall_nxt  = r_t_fall;
        w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt   = PRE;
                    w_timeout_nxt = 1'b0;
                    w_cnt_nxt     = CNT_ZERO;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            PRE: begin
                w_a_nxt = 1'b0;
                if ((r_cnt >= SETTLE_CNT) && !w_ys) begin
                    w_state_nxt = RISE;
                    w_a_nxt     = 1'b1;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = pdm_pkg::DONE;
                    w_timeout_nxt = 1'b1;
                    w_t_rise_nxt  = CNT_MAX;
                    w_t_fall_nxt  = CNT_MAX;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RISE: begin
                if (w_ys) begin
                    w_state_nxt  = FALL;
                    w_t_rise_nxt = r_cnt;
                    w_a_nxt      = 1'b0;
                    w_cnt_nxt    = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = pdm_pkg::DONE;
                    w_timeout_nxt = 1'b1;
                    w_a_nxt       = 1'b0;
                    w_t_rise_nxt  = CNT_MAX;
                    w_t_fall_nxt  = CNT_MAX;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            FALL: begin
                if (!w_ys) begin
                    w_state_nxt  = pdm_pkg::DONE;
                    w_t_fall_nxt = r_cnt;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = pdm_pkg::DONE;
                    w_timeout_nxt = 1'b1;
                    w_a_nxt       = 1'b0;
                    w_t_fall_nxt  = CNT_MAX;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            pdm_pkg::DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_a_nxt     = 1'b0;
            end
        endcase
    end

    // State, counter and result registers
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state   <= IDLE;
            r_cnt     <= CNT_ZERO;
            r_a       <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_t_rise  <= CNT_ZERO;
            r_t_fall  <= CNT_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_a       <= w_a_nxt;
            r_done    <= (w_state_nxt == pdm_pkg::DONE);
            r_timeout <= w_timeout_nxt;
            r_t_rise  <= w_t_rise_nxt;
            r_t_fall  <= w_t_fall_nxt;
        end
    end

    assign A       = r_a;
    assign BUSY    = (r_state != IDLE);
    assign DONE    = r_done;
    assign TIMEOUT = r_timeout;
    assign T_RISE  = r_t_rise;
    assign T_FALL  = r_t_fall;

`ifdef PDM_MINMAX_EN
    logic [CNT_W-1:0] r_t_min, w_t_min_nxt;
    logic [CNT_W-1:0] r_t_max, w_t_max_nxt;
    logic             w_cap;

    // Fold each successful edge capture into the running extremes
    always_comb begin
        w_cap       = ((r_state == RISE) && w_ys) || ((r_state == FALL) && !w_ys);
        w_t_min_nxt = r_t_min;
        w_t_max_nxt = r_t_max;
        if (w_cap) begin
            if (r_cnt < r_t_min) begin
                w_t_min_nxt = r_cnt;
            end else begin
                w_t_min_nxt = r_t_min;
            end
            if (r_cnt > r_t_max) begin
                w_t_max_nxt = r_cnt;
            end else begin
                w_t_max_nxt = r_t_max;
            end
        end else begin
            w_t_min_nxt = r_t_min;
            w_t_max_nxt = r_t_max;
        end
    end

    // Min/max registers
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_t_min <= CNT_MAX;
            r_t_max <= CNT_ZERO;
        end else begin
            r_t_min <= w_t_min_nxt;
            r_t_max <= w_t_max_nxt;
        end
    end

    assign T_MIN = r_t_min;
    assign T_MAX = r_t_max;
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Randomized self-checking bench for path_delay_meter with a delay-line path model.
module tb_path_delay_meter;

    localparam int CW       = 8;
    localparam int SYNC_LAT = 2;
    localparam int LIMIT    = 255;

    logic          c       = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          a;
    logic          y;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] t_rise;
    logic [CW-1:0] t_fall;
`ifdef PDM_MINMAX_EN
    logic [CW-1:0] t_min;
    logic [CW-1:0] t_max;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int mode        = 0;
    int dly_r       = 0;
    int dly_f       = 0;
    int exp_min     = LIMIT;
    int exp_max     = 0;

    logic [15:0] hist = 16'h0000;
    logic [16:0] hist_ext;
    logic        rsrc;
    logic        fsrc;

    path_delay_meter #(.CNT_W(CW), .SETTLE(4)) dut (
        .C       (c),
        .R       (rst_n),
        .START   (start),
        .A       (a),
        .Y       (y),
        .BUSY    (busy),
        .DONE    (done),
        .TIMEOUT (timeout),
        .T_RISE  (t_rise),
        .T_FALL  (t_fall)
`ifdef PDM_MINMAX_EN
        ,
        .T_MIN   (t_min),
        .T_MAX   (t_max)
`endif
    );

    always #5 c = ~c;

    // Path under test: A delayed by dly_r cycles on rise and dly_f cycles on fall
    always @(posedge c) hist <= {hist[14:0], a};

    always_comb begin
        hist_ext = {hist, a};
        rsrc     = hist_ext[dly_r];
        fsrc     = hist_ext[dly_f];
        case (mode)
            0:       y = (dly_r <= dly_f) ? (rsrc | fsrc) : (rsrc & fsrc);
            1:       y = 1'b0;
            default: y = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_minmax();
`ifdef PDM_MINMAX_EN
        check("t_min", 32'(t_min), exp_min);
        check("t_max", 32'(t_max), exp_max);
`endif
    endtask

    task automatic measure(input int er, input int ef, input logic eto, input logic a_stays_low);
        int   cyc;
        logic busy_ok;
        logic a_hi;
        repeat (4) @(negedge c);
        start = 1'b1;
        @(negedge c);
        start   = 1'b0;
        cyc     = 0;
        busy_ok = 1'b1;
        a_hi    = 1'b0;
        while (done !== 1'b1 && cyc < 2000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (a === 1'b1) a_hi = 1'b1;
            @(negedge c);
            cyc++;
        end
        if (!eto) begin
            if (er < exp_min) exp_min = er;
            if (ef < exp_min) exp_min = ef;
            if (er > exp_max) exp_max = er;
            if (ef > exp_max) exp_max = ef;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("t_rise", 32'(t_rise), er);
        check("t_fall", 32'(t_fall), ef);
        check("timeout", 32'(timeout), 32'(eto));
        check("a_low_at_done", 32'(a), 32'd0);
        check("busy_throughout", 32'(busy_ok), 32'd1);
        check("a_went_high", 32'(a_hi), a_stays_low ? 32'd0 : 32'd1);
        check_minmax();
        @(negedge c);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_path(input int dr, input int df);
        mode  = 0;
        dly_r = dr;
        dly_f = df;
        measure(dr + SYNC_LAT, df + SYNC_LAT, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge c);
        rst_n = 1'b0;
        repeat (20) @(negedge c);
        rst_n   = 1'b1;
        exp_min = LIMIT;
        exp_max = 0;
    endtask

    initial begin
        int dr;
        int df;
        int cyc;
        repeat (20) @(negedge c);
        check("rst_a", 32'(a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_t_rise", 32'(t_rise), 32'd0);
        check("rst_t_fall", 32'(t_fall), 32'd0);
        check_minmax();
        rst_n = 1'b1;

        run_path(0, 0);
        run_path(3, 5);
        for (int i = 0; i < 8; i++) begin
            dr = int'($urandom_range(0, 8));
            df = int'($urandom_range(0, 8));
            if (df > 2 * dr + 2) df = 2 * dr + 2;
            run_path(dr, df);
        end

        mode = 1;
        measure(LIMIT, LIMIT, 1'b1, 1'b0);
        mode = 2;
        measure(LIMIT, LIMIT, 1'b1, 1'b1);
        run_path(1, 2);

        // Reset in the middle of a rise measurement
        mode = 1;
        @(negedge c);
        start = 1'b1;
        @(negedge c);
        start = 1'b0;
        cyc   = 0;
        while (a !== 1'b1 && cyc < 100) begin
            @(negedge c);
            cyc++;
        end
        check("rise_entered", 32'(a), 32'd1);
        repeat (5) @(negedge c);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", 32'(a), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_t_rise", 32'(t_rise), 32'd0);
        check("mid_rst_t_fall", 32'(t_fall), 32'd0);
        exp_min = LIMIT;
        exp_max = 0;
        check_minmax();
        repeat (3) @(negedge c);
        check("mid_rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        run_path(0, 0);

`ifdef PDM_MINMAX_EN
        do_reset();
        run_path(3, 3);
        run_path(6, 6);
        check("minmax_min", 32'(t_min), 32'd5);
        check("minmax_max", 32'(t_max), 32'd8);
        mode = 1;
        measure(LIMIT, LIMIT, 1'b1, 1'b0);
        check("minmax_min_after_to", 32'(t_min), 32'd5);
        check("minmax_max_after_to", 32'(t_max), 32'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
